// File: rtl/idma_reg64_driver_pkg.sv
// Shared constants for the 64-bit iDMA register-frontend driver: register map,
// CONF bit positions, FSM state encoding and default register_interface types.
package idma_reg64_driver_pkg;

    localparam int unsigned REG_AW = 32;
    localparam int unsigned REG_DW = 64;

    typedef struct packed {
        logic [REG_AW-1:0]   addr;
        logic                write;
        logic [REG_DW-1:0]   wdata;
        logic [REG_DW/8-1:0] wstrb;
        logic                valid;
    } reg64_req_t;

    typedef struct packed {
        logic [REG_DW-1:0] rdata;
        logic              error;
        logic              ready;
    } reg64_rsp_t;

    localparam logic [7:0] OFF_SRC     = 8'h00;
    localparam logic [7:0] OFF_DST     = 8'h08;
    localparam logic [7:0] OFF_LEN     = 8'h10;
    localparam logic [7:0] OFF_CONF    = 8'h18;
    localparam logic [7:0] OFF_STATUS  = 8'h20;
    localparam logic [7:0] OFF_NEXT_ID = 8'h28;
    localparam logic [7:0] OFF_DONE    = 8'h30;

    localparam int unsigned CONF_DECOUPLE_BIT = 0;
    localparam int unsigned CONF_DEBURST_BIT  = 1;

    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_WR_SRC    = 3'd1;
    localparam logic [STATE_W-1:0] ST_WR_DST    = 3'd2;
    localparam logic [STATE_W-1:0] ST_WR_LEN    = 3'd3;
    localparam logic [STATE_W-1:0] ST_WR_CONF   = 3'd4;
    localparam logic [STATE_W-1:0] ST_RD_ID     = 3'd5;
    localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd6;

    // Each non-idle state owns exactly one register, so the address is a pure
    // function of the state.
    function automatic logic [7:0] state_offset(input logic [STATE_W-1:0] st);
        logic [7:0] off;
        off = OFF_SRC;
        case (st)
            ST_WR_DST:    off = OFF_DST;
            ST_WR_LEN:    off = OFF_LEN;
            ST_WR_CONF:   off = OFF_CONF;
            ST_RD_ID:     off = OFF_NEXT_ID;
            ST_WAIT_DONE: off = OFF_DONE;
            default:      off = OFF_SRC;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/idma_reg64_driver.sv
// Register-interface initiator: programs one iDMA job (SRC, DST, LEN, CONF),
// launches it by reading NEXT_ID and optionally polls DONE until it retires.
module idma_reg64_driver
    import idma_reg64_driver_pkg::*;
#(
    parameter type                  reg_req_t = reg64_req_t,
    parameter type                  reg_rsp_t = reg64_rsp_t,
    parameter int unsigned          AddrWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter bit                   WaitDone  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [63:0]        job_src_i,
    input  logic [63:0]        job_dst_i,
    input  logic [63:0]        job_len_i,
    input  logic               job_decouple_i,
    input  logic               job_deburst_i,
    output reg_req_t           reg_req_o,
    input  reg_rsp_t           reg_rsp_i,
    output logic               id_valid_o,
    output logic [63:0]        id_o,
    output logic               done_o,
    output logic               err_o,
    output logic               busy_o,
    output logic [STATE_W-1:0] dbg_state_o
);

    // Bus handshake: a request is live whenever valid is high; it completes in
    // the cycle valid && ready, and addr/wdata/write are held until then because
    // they derive only from the current state and the latched job.
    logic [STATE_W-1:0] state_q;
    logic [63:0]        src_q, dst_q, len_q, id_q;
    logic               decouple_q, deburst_q;
    logic               id_valid_q, done_q, err_q;
    logic               is_write, xfer_done;
    logic [63:0]        wdata, id_delta;

    assign job_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;
    assign id_valid_o  = id_valid_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign id_o        = id_q;

    assign is_write  = (state_q == ST_WR_SRC) || (state_q == ST_WR_DST) ||
                       (state_q == ST_WR_LEN) || (state_q == ST_WR_CONF);
    assign xfer_done = (state_q != ST_IDLE) && reg_rsp_i.ready;
    // Wrap-safe retirement test: the DONE counter has reached our ID when the
    // 64-bit difference is non-negative.
    assign id_delta  = reg_rsp_i.rdata - id_q;

    always_comb begin
        wdata = '0;
        case (state_q)
            ST_WR_SRC: wdata = src_q;
            ST_WR_DST: wdata = dst_q;
            ST_WR_LEN: wdata = len_q;
            ST_WR_CONF: begin
                wdata[CONF_DECOUPLE_BIT] = decouple_q;
                wdata[CONF_DEBURST_BIT]  = deburst_q;
            end
            default: wdata = '0;
        endcase
    end

    always_comb begin
        reg_req_o       = '0;
        reg_req_o.valid = (state_q != ST_IDLE);
        reg_req_o.addr  = BaseAddr + AddrWidth'(state_offset(state_q));
        reg_req_o.write = is_write;
        reg_req_o.wdata = wdata;
        reg_req_o.wstrb = is_write ? '1 : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            decouple_q <= 1'b0;
            deburst_q  <= 1'b0;
            id_q       <= '0;
            id_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            id_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (job_valid_i) begin
                    src_q      <= job_src_i;
                    dst_q      <= job_dst_i;
                    len_q      <= job_len_i;
                    decouple_q <= job_decouple_i;
                    deburst_q  <= job_deburst_i;
                    if (job_len_i == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        state_q <= ST_WR_SRC;
                    end
                end
            end else if (xfer_done) begin
                if (reg_rsp_i.error) begin
                    err_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end else begin
                    case (state_q)
                        ST_WR_SRC:  state_q <= ST_WR_DST;
                        ST_WR_DST:  state_q <= ST_WR_LEN;
                        ST_WR_LEN:  state_q <= ST_WR_CONF;
                        ST_WR_CONF: state_q <= ST_RD_ID;
                        ST_RD_ID: begin
                            // A zero ID means the frontend refused the launch.
                            if (reg_rsp_i.rdata == '0) begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                id_q       <= reg_rsp_i.rdata;
                                id_valid_q <= 1'b1;
                                state_q    <= WaitDone ? ST_WAIT_DONE : ST_IDLE;
                            end
                        end
                        ST_WAIT_DONE: begin
                            if (!id_delta[63]) begin
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/idma_reg64_driver.md
Name: idma_reg64_driver

Overview:
- Register-interface initiator that programs a 64-bit iDMA register frontend from a stream of transfer jobs.
- Per job: writes source, destination, length and config registers, then reads NEXT_ID to launch the transfer.
- Optionally polls DONE until that ID has retired.
- Sits between a core-side job queue (or test sequencer) and the DMA config slave port.

Parameters:
- reg_req_t, logic: register_interface request type (addr, write, wdata, wstrb, valid).
- reg_rsp_t, logic: register_interface response type (rdata, error, ready).
- AddrWidth, 32: register address width.
- BaseAddr, '0: base address of the DMA frontend register block.
- WaitDone, 1'b1: 1 = poll DONE after launch before accepting the next job; 0 = report ID and return to IDLE.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- job_valid_i  in  1  job request valid
- job_ready_o  out  1  job accepted when valid&&ready
- job_src_i  in  64  source address
- job_dst_i  in  64  destination address
- job_len_i  in  64  length in bytes
- job_decouple_i  in  1  conf.decouple
- job_deburst_i  in  1  conf.deburst
- reg_req_o  out  reg_req_t  register request to DMA frontend
- reg_rsp_i  in  reg_rsp_t  register response
- id_valid_o  out  1  one-cycle pulse: transfer launched
- id_o  out  64  transfer ID read from NEXT_ID (held until next launch)
- done_o  out  1  one-cycle pulse: launched ID retired (WaitDone=1 only)
- err_o  out  1  one-cycle pulse: zero-length job or bus error
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (sync, rst_ni low at posedge):
  - FSM to IDLE.
  - reg_req_o.valid=0; id_valid_o=0; done_o=0; err_o=0; busy_o=0; id_o=0.
  - job_ready_o=1 in IDLE.
- Job capture:
  - In IDLE, job_ready_o=1; the job is latched on handshake.
  - job_len_i==0: no bus traffic, err_o pulses the next cycle, stay IDLE.
- FSM: IDLE -> WR_SRC -> WR_DST -> WR_LEN -> WR_CONF -> RD_ID -> (WAIT_DONE if WaitDone) -> IDLE.
- Register offsets from BaseAddr: SRC 0x00, DST 0x08, LEN 0x10, CONF 0x18, STATUS 0x20, NEXT_ID 0x28, DONE 0x30.
- CONF wdata: bit0=decouple, bit1=deburst, others 0.
- Writes: wstrb='1, write=1. Reads: write=0, wstrb=0.
- Bus handshake:
  - valid asserts in the cycle the state is entered.
  - addr, wdata and write stay stable while valid && !ready.
  - Completion is the cycle valid&&ready; the next state is entered the following cycle (no idle bubble required beyond that).
  - Minimum job latency with ready always 1: 5 cycles to id_valid_o.
- RD_ID:
  - On completion, id_o <= rdata and id_valid_o pulses next cycle.
  - rdata==0 (frontend rejected) -> err_o pulse instead, return IDLE.
- WAIT_DONE:
  - Issues DONE reads back-to-back.
  - Retired when $signed(rdata - id_o) >= 0 (wrap-safe 64-bit compare).
  - On retirement: done_o pulse, IDLE.
- Error: reg_rsp_i.error on any completion -> err_o pulse, abandon the job, IDLE. No retry.
- busy_o=1 in every state except IDLE.
- Reset mid-transaction: the request is dropped immediately (valid=0 next cycle); the job is lost.

Decomposition:
- Shared package idma_reg64_driver_pkg:
  - register offset localparams.
  - state enum.
  - CONF bit positions.
- No sub-module; one FSM plus job and ID registers.

Test Plan:
- Job src=0x1000, dst=0x2000, len=0x40, decouple=1, ready=1, NEXT_ID rdata=5, DONE returns 4 then 5:
  - writes to BaseAddr+0x00/0x08/0x10/0x18 with data 0x1000/0x2000/0x40/0x1.
  - id_valid_o with id_o=5 five cycles after accept.
  - done_o after the second DONE read.
- ready held low 3 cycles on the WR_DST write: addr and wdata stable throughout; only one write completes.
- job_len=0: no reg_req_o.valid ever; err_o pulses once; job_ready_o returns 1.
- error=1 on the WR_LEN completion: err_o pulse; no CONF write or NEXT_ID read; busy_o drops.
- Wrap case: id_o=0xFFFF_FFFF_FFFF_FFFF, DONE returns 0xFFFF_FFFF_FFFF_FFFE then 0x0: done_o only after the 0x0 read.
- rst_ni low during WR_CONF with valid=1: the next cycle shows valid=0, IDLE, and all pulse outputs 0.
